// File: rtl/kairo_clint_pkg.sv
// -----------------------------------------------------------------------------
// kairo_clint_pkg
// Shared definitions for the core-local interruptor (CLINT):
//   - byte offsets of the memory-mapped registers
//   - reset value of mtimecmp
//   - byte-lane strobe merge helper used by every writable register
// -----------------------------------------------------------------------------
package kairo_clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFS        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFS    = 16'hBFFC;

  // All ones keeps TIMER_EXPIRED low out of reset until software programs a compare value.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Merge new_w into old_w one byte lane at a time, under control of strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kairo_clint_prescaler.sv
// -----------------------------------------------------------------------------
// kairo_clint_prescaler
// Divides CLK by TICK_DIV to produce the single-cycle mtime increment pulse.
// The counter runs 0..TICK_DIV-1; tick_o is high in the cycle where the count
// equals TICK_DIV-1, and the counter wraps to 0 on that edge. While hold_i is
// high the counter keeps its value and no tick is produced.
//
// Ports:
//   CLK     in   clock
//   RST_N   in   synchronous active-low reset (counter -> 0)
//   hold_i  in   freeze counter and suppress tick
//   tick_o  out  mtime increment pulse (combinational from the counter)
// -----------------------------------------------------------------------------
module kairo_clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic hold_i,
  output logic tick_o
);

  localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!hold_i) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = 16'd0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/kairo_clint.sv
// -----------------------------------------------------------------------------
// kairo_clint
// Core-local interruptor feeding the CSR/trap logic. Holds the 64-bit machine
// timer (mtime), its compare register (mtimecmp) and the software interrupt
// bit (msip), exposed as a 32-bit memory-mapped slave with a single-beat
// ENA/READY handshake (fixed one-cycle latency, back-to-back accesses legal).
//
// Register map (word aligned, BUS_ADDR[1:0] ignored):
//   0x0000 msip (bit0)   0x4000/0x4004 mtimecmp lo/hi   0xBFF8/0xBFFC mtime lo/hi
//   Unmapped addresses read 0, ignore writes, and still complete.
//
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   BUS_ENA/BUS_WE    access strobe / write select
//   BUS_ADDR          byte address (ADDR_W bits)
//   BUS_WSTRB/WDATA   write byte enables / data
//   BUS_RDATA/READY   registered read data / one-cycle completion pulse
//   DEBUG_HALT        core debug halt (only used with the option below)
//   TIMER_EXPIRED     registered (mtime >= mtimecmp), unsigned 64-bit
//   MSIP              software interrupt pending
//
// Build option: define KAIRO_CLINT_DEBUG_HALT_EN to freeze the prescaler and
// mtime while DEBUG_HALT is high (bus writes still apply). Without it,
// DEBUG_HALT is ignored.
// -----------------------------------------------------------------------------
module kairo_clint
  import kairo_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BUS_ENA,
  input  logic              BUS_WE,
  input  logic [ADDR_W-1:0] BUS_ADDR,
  input  logic [3:0]        BUS_WSTRB,
  input  logic [31:0]       BUS_WDATA,
  output logic [31:0]       BUS_RDATA,
  output logic              BUS_READY,
  input  logic              DEBUG_HALT,
  output logic              TIMER_EXPIRED,
  output logic              MSIP
);

  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q,     msip_d;
  logic        expired_q,  expired_d;
  logic [31:0] rdata_q,    rdata_d;
  logic        ready_q;

  logic        tick;
  logic        halt;
  logic        wr;
  logic [31:0] rd_mux;
  logic [ADDR_W-1:0] word_addr;
  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;

`ifdef KAIRO_CLINT_DEBUG_HALT_EN
  assign halt = DEBUG_HALT;
`else
  logic unused_debug_halt;
  assign halt              = 1'b0;
  assign unused_debug_halt = DEBUG_HALT;
`endif

  kairo_clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .hold_i (halt),
    .tick_o (tick)
  );

  // Byte lane bits are not part of the register selection.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = BUS_ADDR[1:0];
  assign word_addr       = {BUS_ADDR[ADDR_W-1:2], 2'b00};

  assign sel_msip     = (word_addr == ADDR_W'(CLINT_MSIP_OFS));
  assign sel_cmp_lo   = (word_addr == ADDR_W'(CLINT_MTIMECMP_LO_OFS));
  assign sel_cmp_hi   = (word_addr == ADDR_W'(CLINT_MTIMECMP_HI_OFS));
  assign sel_mtime_lo = (word_addr == ADDR_W'(CLINT_MTIME_LO_OFS));
  assign sel_mtime_hi = (word_addr == ADDR_W'(CLINT_MTIME_HI_OFS));

  assign wr = BUS_ENA & BUS_WE;

  always_comb begin
    rd_mux = 32'd0;
    if      (sel_msip)     rd_mux = {31'd0, msip_q};
    else if (sel_cmp_lo)   rd_mux = mtimecmp_q[31:0];
    else if (sel_cmp_hi)   rd_mux = mtimecmp_q[63:32];
    else if (sel_mtime_lo) rd_mux = mtime_q[31:0];
    else if (sel_mtime_hi) rd_mux = mtime_q[63:32];
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;

    // A bus write to either mtime word takes priority over the tick; the
    // increment for that cycle is lost while the prescaler keeps running.
    if (wr && sel_mtime_lo && (|BUS_WSTRB)) begin
      mtime_d[31:0] = apply_wstrb(mtime_q[31:0], BUS_WDATA, BUS_WSTRB);
    end else if (wr && sel_mtime_hi && (|BUS_WSTRB)) begin
      mtime_d[63:32] = apply_wstrb(mtime_q[63:32], BUS_WDATA, BUS_WSTRB);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr && sel_cmp_lo) mtimecmp_d[31:0]  = apply_wstrb(mtimecmp_q[31:0], BUS_WDATA, BUS_WSTRB);
    if (wr && sel_cmp_hi) mtimecmp_d[63:32] = apply_wstrb(mtimecmp_q[63:32], BUS_WDATA, BUS_WSTRB);
    if (wr && sel_msip && BUS_WSTRB[0]) msip_d = BUS_WDATA[0];

    if (BUS_ENA && !BUS_WE) rdata_d = rd_mux;

    // Compare the post-edge values so the flag tracks the registers it is
    // derived from rather than lagging them by a further cycle.
    expired_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      msip_q     <= 1'b0;
      expired_q  <= 1'b0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      expired_q  <= expired_d;
      rdata_q    <= rdata_d;
      ready_q    <= BUS_ENA;
    end
  end

  assign BUS_RDATA     = rdata_q;
  assign BUS_READY     = ready_q;
  assign TIMER_EXPIRED = expired_q;
  assign MSIP          = msip_q;

endmodule

// File: tb/tb_kairo_clint.sv
// -----------------------------------------------------------------------------
// tb_kairo_clint
// Directed bench for kairo_clint. Two instances share the bus inputs:
// u_div1 (TICK_DIV=1) and u_div4 (TICK_DIV=4). Inputs are driven 1ns after a
// rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_kairo_clint;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        BUS_ENA;
  logic        BUS_WE;
  logic [15:0] BUS_ADDR;
  logic [3:0]  BUS_WSTRB;
  logic [31:0] BUS_WDATA;
  logic        DEBUG_HALT;

  logic [31:0] rdata1, rdata4;
  logic        ready1, ready4;
  logic        te1, te4;
  logic        msip1, msip4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  kairo_clint #(.TICK_DIV(1), .ADDR_W(16)) u_div1 (
    .CLK(CLK), .RST_N(RST_N), .BUS_ENA(BUS_ENA), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WSTRB(BUS_WSTRB), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(rdata1), .BUS_READY(ready1),
    .DEBUG_HALT(DEBUG_HALT), .TIMER_EXPIRED(te1), .MSIP(msip1)
  );

  kairo_clint #(.TICK_DIV(4), .ADDR_W(16)) u_div4 (
    .CLK(CLK), .RST_N(RST_N), .BUS_ENA(BUS_ENA), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WSTRB(BUS_WSTRB), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(rdata4), .BUS_READY(ready4),
    .DEBUG_HALT(DEBUG_HALT), .TIMER_EXPIRED(te4), .MSIP(msip4)
  );

  // Ends 1ns after the last reset edge with RST_N released.
  task automatic do_reset();
    RST_N = 1'b0; BUS_ENA = 1'b0; BUS_WE = 1'b0; BUS_ADDR = 16'h0;
    BUS_WSTRB = 4'h0; BUS_WDATA = 32'h0; DEBUG_HALT = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // One-cycle bus strobe; returns 1ns after the sampling edge.
  task automatic bus(input logic we, input logic [15:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
    BUS_ENA = 1'b1; BUS_WE = we; BUS_ADDR = addr; BUS_WSTRB = strb; BUS_WDATA = wdata;
    @(posedge CLK);
    #1;
    BUS_ENA = 1'b0; BUS_WE = 1'b0; BUS_WSTRB = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (ready1 !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%0b exp=0", ready1); end
    vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got=%h exp=0", rdata1); end
    vectors++; if (te1 !== 1'b0) begin miscompares++; $display("FAIL rst_timer_expired got=%0b exp=0", te1); end
    vectors++; if (msip1 !== 1'b0) begin miscompares++; $display("FAIL rst_msip got=%0b exp=0", msip1); end
    bus(1'b0, 16'h4000, 4'h0, 32'h0);
    vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL rst_cmp_ready got=%0b exp=1", ready1); end
    vectors++; if (rdata1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL rst_cmp_lo got=%h exp=ffffffff", rdata1); end
    idle(1);
    vectors++; if (ready1 !== 1'b0) begin miscompares++; $display("FAIL ready_one_cycle got=%0b exp=0", ready1); end
    vectors++; if (rdata1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL rdata_hold got=%h exp=ffffffff", rdata1); end
    vectors++; if (te1 !== 1'b0 || msip1 !== 1'b0) begin miscompares++; $display("FAIL post_rst_irq got=%0b%0b exp=00", te1, msip1); end
  endtask

  task automatic test_prescale_back_to_back();
    do_reset();
    idle(40);
    vectors++; if (ready4 !== 1'b0) begin miscompares++; $display("FAIL div4_idle_ready got=%0b exp=0", ready4); end
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    BUS_ENA = 1'b1; BUS_ADDR = 16'hBFFC;
    vectors++; if (ready4 !== 1'b1) begin miscompares++; $display("FAIL div4_rd_lo_ready got=%0b exp=1", ready4); end
    vectors++; if (rdata4 !== 32'd10) begin miscompares++; $display("FAIL div4_mtime_lo got=%0d exp=10", rdata4); end
    vectors++; if (rdata1 !== 32'd40) begin miscompares++; $display("FAIL div1_mtime_lo got=%0d exp=40", rdata1); end
    @(posedge CLK); #1;
    BUS_ENA = 1'b0;
    vectors++; if (ready4 !== 1'b1) begin miscompares++; $display("FAIL b2b_second_ready got=%0b exp=1", ready4); end
    vectors++; if (rdata4 !== 32'd0) begin miscompares++; $display("FAIL div4_mtime_hi got=%h exp=0", rdata4); end
    idle(1);
    vectors++; if (ready4 !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_drop got=%0b exp=0", ready4); end
  endtask

  task automatic test_compare();
    do_reset();
    bus(1'b1, 16'h4004, 4'hF, 32'd0);
    bus(1'b1, 16'h4000, 4'hF, 32'd20);
    bus(1'b1, 16'hBFF8, 4'hF, 32'd0);
    idle(19);
    vectors++; if (te1 !== 1'b0) begin miscompares++; $display("FAIL cmp_below got=%0b exp=0", te1); end
    idle(1);
    vectors++; if (te1 !== 1'b1) begin miscompares++; $display("FAIL cmp_reach got=%0b exp=1", te1); end
    idle(3);
    vectors++; if (te1 !== 1'b1) begin miscompares++; $display("FAIL cmp_level got=%0b exp=1", te1); end
    bus(1'b1, 16'h4000, 4'hF, 32'd100);
    vectors++; if (te1 !== 1'b0) begin miscompares++; $display("FAIL cmp_raise got=%0b exp=0", te1); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF);
    bus(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF);
    vectors++; if (te1 !== 1'b1) begin miscompares++; $display("FAIL wrap_allones_expired got=%0b exp=1", te1); end
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_pre_lo got=%h exp=ffffffff", rdata1); end
    vectors++; if (te1 !== 1'b0) begin miscompares++; $display("FAIL wrap_expired_drop got=%0b exp=0", te1); end
    bus(1'b0, 16'hBFFC, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL wrap_hi got=%h exp=0", rdata1); end
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'd1) begin miscompares++; $display("FAIL wrap_lo_after got=%h exp=1", rdata1); end
  endtask

  task automatic test_strobe();
    do_reset();
    bus(1'b1, 16'hBFF8, 4'hF, 32'h1234_5678);
    bus(1'b1, 16'hBFF8, 4'b0010, 32'h0000_AB00);
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'h1234_AB78) begin miscompares++; $display("FAIL strb_byte1 got=%h exp=1234ab78", rdata1); end
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'h1234_AB79) begin miscompares++; $display("FAIL strb_resume got=%h exp=1234ab79", rdata1); end
    bus(1'b0, 16'hBFFC, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL strb_hi_held got=%h exp=0", rdata1); end
    bus(1'b1, 16'h4000, 4'h0, 32'h0);
    vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL strb0_ready got=%0b exp=1", ready1); end
    bus(1'b0, 16'h4003, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL strb0_noupdate got=%h exp=ffffffff", rdata1); end
    bus(1'b1, 16'h1230, 4'hF, 32'hDEAD_BEEF);
    bus(1'b0, 16'h1230, 4'h0, 32'h0);
    vectors++; if (ready1 !== 1'b1 || rdata1 !== 32'h0) begin miscompares++; $display("FAIL unmapped got=%0b/%h exp=1/0", ready1, rdata1); end
  endtask

  task automatic test_msip();
    do_reset();
    bus(1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFF);
    vectors++; if (msip1 !== 1'b1) begin miscompares++; $display("FAIL msip_set got=%0b exp=1", msip1); end
    bus(1'b0, 16'h0000, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'h1) begin miscompares++; $display("FAIL msip_read got=%h exp=1", rdata1); end
    bus(1'b1, 16'h0000, 4'b1110, 32'hFFFF_FFFE);
    vectors++; if (msip1 !== 1'b1) begin miscompares++; $display("FAIL msip_lane0_off got=%0b exp=1", msip1); end
    bus(1'b1, 16'h0000, 4'b0001, 32'h0);
    vectors++; if (msip1 !== 1'b0) begin miscompares++; $display("FAIL msip_clear got=%0b exp=0", msip1); end
    bus(1'b0, 16'h0000, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL msip_read0 got=%h exp=0", rdata1); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    RST_N = 1'b0;
    bus(1'b0, 16'h4000, 4'h0, 32'h0);
    vectors++; if (ready1 !== 1'b0 || rdata1 !== 32'h0) begin miscompares++; $display("FAIL rst_mid_rd got=%0b/%h exp=0/0", ready1, rdata1); end
    bus(1'b1, 16'h4000, 4'hF, 32'd5);
    RST_N = 1'b1;
    bus(1'b0, 16'h4000, 4'h0, 32'h0);
    vectors++; if (rdata1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL rst_mid_wr got=%h exp=ffffffff", rdata1); end
  endtask

  task automatic test_debug_halt();
    logic [31:0] exp_a, exp_b;
`ifdef KAIRO_CLINT_DEBUG_HALT_EN
    exp_a = 32'd0;  exp_b = 32'd10;
`else
    exp_a = 32'd50; exp_b = 32'd60;
`endif
    do_reset();
    DEBUG_HALT = 1'b1;
    idle(50);
    DEBUG_HALT = 1'b0;
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    vectors++; if (rdata1 !== exp_a) begin miscompares++; $display("FAIL halt_window got=%0d exp=%0d", rdata1, exp_a); end
    idle(9);
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    vectors++; if (rdata1 !== exp_b) begin miscompares++; $display("FAIL halt_resume got=%0d exp=%0d", rdata1, exp_b); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_prescale_back_to_back();
    test_compare();
    test_wrap();
    test_strobe();
    test_msip();
    test_reset_mid_access();
    test_debug_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
